// File: rtl/axis_hdr_pkg.sv
// axis_hdr_pkg: state encoding and keep-vector helpers shared by the header insert/extract blocks.
// Helpers work on a MAX_BYTES-wide vector and take the real byte width as an argument.
package axis_hdr_pkg;

    localparam int MAX_BYTES = 64;

    localparam logic [1:0] ST_HDR   = 2'd0;
    localparam logic [1:0] ST_BODY  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    function automatic logic [7:0] lead_ones(input logic [MAX_BYTES-1:0] keep, input int w);
        logic [7:0] cnt;
        logic run;
        cnt = 8'd0;
        run = 1'b1;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < w) begin
                if (run && keep[w-1-i]) cnt = cnt + 8'd1;
                else run = 1'b0;
            end
        end
        return cnt;
    endfunction

    function automatic logic [MAX_BYTES-1:0] ones_mask(input int n, input int w);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < w && i >= w - n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// axis_byte_merge: joins the carried residual with the top n bytes of a new beat,
// and produces the beat's leftover bytes shifted up to become the next residual.
module axis_byte_merge #(
    parameter int DATA_WD = 32,
    parameter int CNT_WD  = 3
) (
    input  logic [DATA_WD-1:0] residual,
    input  logic [DATA_WD-1:0] beat,
    input  logic [CNT_WD-1:0]  n,
    output logic [DATA_WD-1:0] merged,
    output logic [DATA_WD-1:0] shifted
);

    assign shifted = beat << (8 * int'(n));
    assign merged  = residual | (beat >> (DATA_WD - 8 * int'(n)));

endmodule

// File: rtl/axi_stream_extract_header.sv
// axi_stream_extract_header: strips an N-byte header off the first beat of each frame
// onto a header channel and realigns the remaining payload into full MSB-first beats.
module axi_stream_extract_header
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt
);

    localparam int CW = BYTE_CNT_WD + 1;

    logic [1:0]         state;
    logic [CW-1:0]      n_r, rem_r, n_cur, k;
    logic [DATA_WD-1:0] res_r, din_m, merged, shifted;
    logic               out_free, accept, k_gt_n;

    // Header length comes straight from the port on the first beat, from the latch afterwards
    assign n_cur    = (state == ST_HDR) ? CW'(byte_strip_cnt) + CW'(1) : n_r;
    assign k        = CW'(lead_ones(MAX_BYTES'(keep_in), DATA_BYTE_WD));
    assign k_gt_n   = k > n_cur;
    assign out_free = !valid_out || ready_out;
    assign ready_in = rst_n && ((state == ST_BODY && out_free) ||
                                (state == ST_HDR && out_free && (!valid_header || ready_header)));
    assign accept   = valid_in && ready_in;

    // Zero disabled bytes up front so every derived beat is already clean
    for (genvar b = 0; b < DATA_BYTE_WD; b++) begin : g_mask
        assign din_m[8*b +: 8] = keep_in[b] ? data_in[8*b +: 8] : 8'h00;
    end

    axis_byte_merge #(
        .DATA_WD (DATA_WD),
        .CNT_WD  (CW)
    ) u_merge (
        .residual (res_r),
        .beat     (din_m),
        .n        (n_cur),
        .merged   (merged),
        .shifted  (shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_HDR;
            n_r          <= '0;
            rem_r        <= '0;
            res_r        <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            valid_header <= 1'b0;
            data_header  <= '0;
            keep_header  <= '0;
        end else begin
            if (ready_header) valid_header <= 1'b0;
            if (out_free) valid_out <= 1'b0;
            if (accept) res_r <= shifted;
            if (accept && state == ST_HDR) begin
                n_r          <= n_cur;
                valid_header <= 1'b1;
                data_header  <= din_m & ~({DATA_WD{1'b1}} >> (8 * int'(n_cur)));
                keep_header  <= DATA_BYTE_WD'(ones_mask(int'(k_gt_n ? n_cur : k), DATA_BYTE_WD));
                state        <= last_in ? ST_HDR : ST_BODY;
                if (last_in && k_gt_n) begin
                    valid_out <= 1'b1;
                    data_out  <= shifted;
                    keep_out  <= DATA_BYTE_WD'(ones_mask(int'(k - n_cur), DATA_BYTE_WD));
                    last_out  <= 1'b1;
                end
            end
            if (accept && state == ST_BODY) begin
                valid_out <= 1'b1;
                data_out  <= merged;
                keep_out  <= (last_in && !k_gt_n) ?
                             DATA_BYTE_WD'(ones_mask(DATA_BYTE_WD - int'(n_cur) + int'(k), DATA_BYTE_WD)) : '1;
                last_out  <= last_in && !k_gt_n;
                rem_r     <= k - n_cur;
                state     <= !last_in ? ST_BODY : (k_gt_n ? ST_FLUSH : ST_HDR);
            end
            // Last input beat overflowed the output width: emit its tail on its own
            if (state == ST_FLUSH && out_free) begin
                valid_out <= 1'b1;
                data_out  <= res_r;
                keep_out  <= DATA_BYTE_WD'(ones_mask(int'(rem_r), DATA_BYTE_WD));
                last_out  <= 1'b1;
                state     <= ST_HDR;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// tb_axi_stream_extract_header: random and directed frames checked against a byte-stream model
// of header stripping and payload repacking.
module tb_axi_stream_extract_header;

    localparam int DW = 32;
    localparam int DB = 4;
    localparam int CW = 2;

    typedef logic [7:0] bytes_t[$];
    typedef struct packed {
        logic [DW-1:0] d;
        logic [DB-1:0] k;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DB-1:0] keep_in = '0;
    logic          last_in = 1'b0;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [DB-1:0] keep_out;
    logic          last_out;
    logic          ready_out = 1'b0;
    logic          valid_header;
    logic [DW-1:0] data_header;
    logic [DB-1:0] keep_header;
    logic          ready_header = 1'b0;
    logic [CW-1:0] byte_strip_cnt = '0;

    beat_t out_q[$], hdr_q[$];
    beat_t e;
    int checks = 0, errors = 0;
    logic mon_en = 1'b0, full_rdy = 1'b1, force_lo = 1'b0, gaps = 1'b0, first_beat = 1'b0;
    logic hold_o = 1'b0, hold_h = 1'b0;
    logic [37:0] prev_o;
    logic [36:0] prev_h;

    always #5 clk = ~clk;

    axi_stream_extract_header #(.DATA_WD(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .ready_in       (ready_in),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .ready_out      (ready_out),
        .valid_header   (valid_header),
        .data_header    (data_header),
        .keep_header    (keep_header),
        .ready_header   (ready_header),
        .byte_strip_cnt (byte_strip_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic beat_t pack_bytes(input bytes_t b, input int from, input int cnt, input logic l);
        beat_t r;
        r = '0;
        for (int i = 0; i < cnt; i++) begin
            r.d[DW-1-8*i -: 8] = b[from+i];
            r.k[DB-1-i] = 1'b1;
        end
        r.l = l;
        return r;
    endfunction

    // Model: header = first min(N,len) bytes; payload = bytes N.. repacked DB per beat
    task automatic send_frame(input int n, input bytes_t b);
        int len, nb, t;
        len = b.size();
        nb = (len + DB - 1) / DB;
        hdr_q.push_back(pack_bytes(b, 0, (n < len) ? n : len, 1'b0));
        for (int p = n; p < len; p += DB)
            out_q.push_back(pack_bytes(b, p, (len - p < DB) ? len - p : DB, p + DB >= len));
        for (int j = 0; j < nb; j++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                valid_in = 1'b0;
                data_in = $urandom;
                byte_strip_cnt = CW'($urandom);
            end
            @(negedge clk);
            data_in = $urandom;
            keep_in = '0;
            for (int i = 0; i < DB; i++) begin
                if (j * DB + i < len) begin
                    data_in[DW-1-8*i -: 8] = b[j*DB+i];
                    keep_in[DB-1-i] = 1'b1;
                end
            end
            valid_in = 1'b1;
            last_in = (j == nb - 1);
            first_beat = (j == 0);
            byte_strip_cnt = (j == 0) ? CW'(n - 1) : CW'($urandom);
            #1;
            t = 0;
            while (!ready_in) begin
                @(negedge clk);
                #1;
                t++;
                if (t > 1000) begin
                    $display("FAIL in_timeout ready_in stuck low");
                    $fatal(1);
                end
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        valid_in = 1'b0;
        while ((out_q.size() != 0 || hdr_q.size() != 0) && t < 5000) begin
            @(negedge clk);
            #3;
            t++;
        end
        check("drain_out", 64'(out_q.size()), 64'(0));
        check("drain_hdr", 64'(hdr_q.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        ready_out = !force_lo && (full_rdy || $urandom_range(0, 3) != 0);
        ready_header = full_rdy || $urandom_range(0, 3) != 0;
    end

    always @(negedge clk) begin
        #2;
        if (!mon_en) begin
            hold_o = 1'b0;
            hold_h = 1'b0;
        end else begin
            if (hold_o) check("out_hold", 64'({valid_out, data_out, keep_out, last_out}), 64'(prev_o));
            if (hold_h) check("hdr_hold", 64'({valid_header, data_header, keep_header}), 64'(prev_h));
            if (valid_out && !ready_out) check("rdy_in_out_stall", 64'(ready_in), 64'(0));
            if (valid_in && first_beat && valid_header && !ready_header)
                check("rdy_in_hdr_stall", 64'(ready_in), 64'(0));
            if (valid_out && ready_out) begin
                if (out_q.size() == 0) check("out_extra", 64'(valid_out), 64'(0));
                else begin
                    e = out_q.pop_front();
                    check("out_data", 64'(data_out), 64'(e.d));
                    check("out_keep", 64'(keep_out), 64'(e.k));
                    check("out_last", 64'(last_out), 64'(e.l));
                end
            end
            if (valid_header && ready_header) begin
                if (hdr_q.size() == 0) check("hdr_extra", 64'(valid_header), 64'(0));
                else begin
                    e = hdr_q.pop_front();
                    check("hdr_data", 64'(data_header), 64'(e.d));
                    check("hdr_keep", 64'(keep_header), 64'(e.k));
                end
            end
            hold_o = valid_out && !ready_out;
            hold_h = valid_header && !ready_header;
            prev_o = {valid_out, data_out, keep_out, last_out};
            prev_h = {valid_header, data_header, keep_header};
        end
    end

    initial begin
        bytes_t b;
        int n, len;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_out", 64'({valid_out, data_out, keep_out, last_out}), 64'(0));
        check("rst_hdr", 64'({valid_header, data_header, keep_header, ready_in}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        b = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_frame(2, b);
        b = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2};
        send_frame(1, b);
        b = {};
        for (int i = 0; i < 13; i++) b.push_back(8'($urandom));
        send_frame(4, b);
        b = {8'hC0, 8'hC1};
        send_frame(3, b);
        b = {8'hC0, 8'hC1, 8'hC2, 8'hC3};
        send_frame(3, b);
        drain();
        // Stall the output so the N=1 frame parks in its flush beat, then reset
        mon_en = 1'b0;
        force_lo = 1'b1;
        @(negedge clk);
        b = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2};
        send_frame(1, b);
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        check("flush_valid", 64'(valid_out), 64'(1));
        check("flush_data", 64'(data_out), 64'(32'hA1A2A3B0));
        check("flush_ready_in", 64'(ready_in), 64'(0));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out", 64'({valid_out, data_out, keep_out, last_out}), 64'(0));
        check("midrst_hdr", 64'({valid_header, data_header, keep_header, ready_in}), 64'(0));
        out_q.delete();
        hdr_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        force_lo = 1'b0;
        mon_en = 1'b1;
        b = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_frame(2, b);
        drain();
        full_rdy = 1'b0;
        gaps = 1'b1;
        for (int f = 0; f < 300; f++) begin
            n = $urandom_range(1, DB);
            len = ($urandom_range(1, 4) - 1) * DB + $urandom_range(1, DB);
            b = {};
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            send_frame(n, b);
        end
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
